count_ctrl: RTL and testbench

COUNT_CTRL -- requirements
Module: count_ctrl

---
 rtl/count_ctrl.sv | 118 +++++++++++
 tb/tb_count_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/count_ctrl.sv
// Run/stop/clear controller for a downstream 16-bit counter: button synchronizers,
// optional debounce (COUNT_CTRL_DEBOUNCE_EN), press-edge detection, run FSM and tick prescaler.
module count_ctrl #(
  parameter int unsigned DIV    = 50000000,
  parameter int unsigned DB_CNT = 1000000
) (
  input  logic Clk,
  input  logic Reset,
  input  logic BtnRun,
  input  logic BtnClr,
  output logic Enable,
  output logic Clear,
  output logic Running
);

  localparam int unsigned   PW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  typedef enum logic {
    STOPPED = 1'b0,
    RUNNING = 1'b1
  } state_t;

  state_t        state;
  logic [PW-1:0] presc;

  // bit 0 = run button, bit 1 = clear button
  logic [1:0] sync1;
  logic [1:0] sync2;
  logic [1:0] level;
  logic [1:0] level_d;
  logic [1:0] press;
  logic       run_press;
  logic       clr_press;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= {BtnClr, BtnRun};
      sync2 <= sync1;
    end
  end

`ifdef COUNT_CTRL_DEBOUNCE_EN
  localparam int unsigned   DW      = (DB_CNT > 1) ? $clog2(DB_CNT) : 1;
  localparam logic [DW-1:0] DB_LAST = DW'(DB_CNT - 1);

  logic [DW-1:0] db_cnt [2];

  // The level flips on the DB_CNT-th consecutive cycle of disagreement.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      level     <= '0;
      db_cnt[0] <= '0;
      db_cnt[1] <= '0;
    end else begin
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2[i] != level[i]) begin
          if (db_cnt[i] == DB_LAST) begin
            level[i]  <= sync2[i];
            db_cnt[i] <= '0;
          end else begin
            db_cnt[i] <= db_cnt[i] + 1'b1;
          end
        end else begin
          db_cnt[i] <= '0;
        end
      end
    end
  end
`else
  always_comb level = sync2;
`endif

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      level_d <= '0;
    end else begin
      level_d <= level;
    end
  end

  always_comb begin
    press     = level & ~level_d;
    clr_press = press[1];
    run_press = press[0] & ~press[1];
  end

  // Clear wins over run; the prescaler only advances while running so a pause keeps tick phase.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state <= STOPPED;
      presc <= '0;
      Clear <= 1'b0;
    end else begin
      Clear <= clr_press;
      if (clr_press) begin
        state <= STOPPED;
        presc <= '0;
      end else begin
        if (state == RUNNING) begin
          presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
        end
        if (run_press) begin
          state <= (state == RUNNING) ? STOPPED : RUNNING;
        end
      end
    end
  end

  always_comb begin
    Running = (state == RUNNING);
    Enable  = (state == RUNNING) && (presc == PRE_LAST);
  end

endmodule

// File: tb/tb_count_ctrl.sv
// Directed bench for count_ctrl: DIV=4/DB_CNT=3 instance for control behaviour,
// DIV=1 instance for the continuous-enable / 16-bit wrap case.
module tb_count_ctrl;

`ifdef COUNT_CTRL_DEBOUNCE_EN
  localparam int LAT        = 3 + 3;
  localparam int GLITCH_RUN = 1;
`else
  localparam int LAT        = 3;
  localparam int GLITCH_RUN = 0;
`endif
  localparam int PJ = (7 - (LAT % 4)) % 4;

  logic clk = 1'b0;
  logic rst;
  logic btn_run, btn_clr, enable, clear, running;
  logic btn_run1, btn_clr1, enable1, clear1, running1;
  logic [15:0] ds, ds1, ds1_start, ds1_prev, ds1_exp;
  int checks   = 0;
  int failures = 0;
  int n, wraps;

  always #5 clk = ~clk;

  count_ctrl #(.DIV(4), .DB_CNT(3)) dut (
    .Clk(clk), .Reset(rst), .BtnRun(btn_run), .BtnClr(btn_clr),
    .Enable(enable), .Clear(clear), .Running(running)
  );

  count_ctrl #(.DIV(1), .DB_CNT(3)) dut1 (
    .Clk(clk), .Reset(rst), .BtnRun(btn_run1), .BtnClr(btn_clr1),
    .Enable(enable1), .Clear(clear1), .Running(running1)
  );

  // downstream 16-bit counters
  always @(posedge clk or posedge rst) begin
    if (rst)         ds <= '0;
    else if (clear)  ds <= '0;
    else if (enable) ds <= ds + 16'd1;
  end

  always @(posedge clk or posedge rst) begin
    if (rst)          ds1 <= '0;
    else if (clear1)  ds1 <= '0;
    else if (enable1) ds1 <= ds1 + 16'd1;
  end

  task automatic step(input int cycles);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: got 0 expected 1");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; btn_run = 1'b0; btn_clr = 1'b0; btn_run1 = 1'b0; btn_clr1 = 1'b0;
    step(3);
    check_eq("reset_running", running, 0);
    check_eq("reset_enable", enable, 0);
    check_eq("reset_clear", clear, 0);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 20; k++) begin step(1); n += clear; end
    check_eq("no_clear_after_reset", n, 0);

    // run press latency and tick cadence
    btn_run = 1'b1;
    step(LAT - 1);
    check_eq("run_latency_early", running, 0);
    step(1);
    check_eq("run_entry", running, 1);
    for (int k = 1; k <= 12; k++) begin
      step(1);
      if (k == 4) btn_run = 1'b0;
      check_eq($sformatf("tick_%0d", k), enable, (k % 4 == 3));
    end
    check_eq("ds_after_3_ticks", ds, 3);

    // stop on the edge where the prescaler advances 2 -> 3
    step(PJ);
    btn_run = 1'b1;
    step(LAT - 1);
    check_eq("pause_early", running, 1);
    check_eq("pause_phase", enable, 0);
    step(1);
    check_eq("pause_stop", running, 0);
    n = 0;
    for (int k = 0; k < LAT + 10; k++) begin
      step(1);
      if (k == 6) btn_run = 1'b0;
      n += enable;
    end
    check_eq("enable_while_stopped", n, 0);
    btn_run = 1'b1;
    step(LAT - 1);
    check_eq("resume_early", running, 0);
    step(1);
    check_eq("resume_entry", running, 1);
    check_eq("resume_first_tick", enable, 1);
    btn_run = 1'b0;
    step(1);
    check_eq("resume_after_tick", enable, 0);
    step(3);
    check_eq("resume_second_tick", enable, 1);
    step(LAT + 2);

    // clear and run together while running
    btn_run = 1'b1; btn_clr = 1'b1;
    step(LAT - 1);
    check_eq("both_early_running", running, 1);
    check_eq("both_early_clear", clear, 0);
    step(1);
    check_eq("both_stop", running, 0);
    check_eq("both_clear_pulse", clear, 1);
    check_eq("no_enable_with_clear", enable, 0);
    step(1);
    check_eq("clear_one_cycle", clear, 0);
    check_eq("ds_cleared", ds, 0);
    step(4);
    btn_run = 1'b0; btn_clr = 1'b0;
    n = 0;
    for (int k = 0; k < LAT + 6; k++) begin step(1); n += clear; end
    check_eq("no_second_clear", n, 0);
    check_eq("stopped_after_clear", running, 0);

    // prescaler restarts from 0 after clear
    btn_run = 1'b1;
    step(LAT);
    check_eq("post_clear_entry", running, 1);
    check_eq("post_clear_tick0", enable, 0);
    btn_run = 1'b0;
    step(2);
    check_eq("post_clear_tick2", enable, 0);
    step(1);
    check_eq("post_clear_tick3", enable, 1);
    step(LAT + 2);

    // 2-cycle glitch
    btn_run = 1'b1;
    step(2);
    btn_run = 1'b0;
    step(LAT + 4);
    check_eq("glitch", running, GLITCH_RUN);

    // clear alone
    btn_clr = 1'b1;
    n = 0;
    for (int k = 0; k < LAT + 8; k++) begin
      step(1);
      if (k == 5) btn_clr = 1'b0;
      n += clear;
    end
    check_eq("clr_single_pulse", n, 1);
    check_eq("clr_stops", running, 0);

    // held button: exactly one event
    btn_run = 1'b1;
    step(40);
    check_eq("held_one_event", running, 1);

    // async reset with button still held, then full latency after release
    #2 rst = 1'b1;
    #1 check_eq("async_reset_held", running, 0);
    step(2);
    rst = 1'b0;
    step(LAT - 1);
    check_eq("held_at_release_early", running, 0);
    step(1);
    check_eq("held_at_release_press", running, 1);
    btn_run = 1'b0;
    step(3);
    check_eq("pre_reset_tick", enable, 1);
    #2 rst = 1'b1;
    #1;
    check_eq("midtick_reset_running", running, 0);
    check_eq("midtick_reset_enable", enable, 0);
    check_eq("midtick_reset_clear", clear, 0);
    step(1);
    rst = 1'b0;
    n = 0;
    for (int k = 0; k < 100; k++) begin step(1); n += enable; end
    check_eq("idle_100_enable", n, 0);
    check_eq("idle_100_running", running, 0);

    // DIV=1: continuous enable, downstream counter wraps
    btn_run1 = 1'b1;
    step(LAT);
    check_eq("div1_entry", running1, 1);
    check_eq("div1_enable_at_entry", enable1, 1);
    btn_run1 = 1'b0;
    ds1_start = ds1;
    ds1_prev  = ds1;
    n = 0;
    wraps = 0;
    for (int k = 0; k < 70000; k++) begin
      step(1);
      n += enable1;
      if (ds1_prev == 16'hFFFF && ds1 == 16'h0000) wraps++;
      ds1_prev = ds1;
    end
    ds1_exp = ds1_start + 16'(70000);
    check_eq("div1_enable_count", n, 70000);
    check_eq("div1_counter_value", ds1, ds1_exp);
    check_eq("div1_wraps", wraps, 1);
    check_eq("div1_no_clear", clear1, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
